// File: rtl/alu_pkg.sv
// Shared types for the ALU family: the 4-bit slice operands, the slice
// result-mux select, and the wrapper-level command/control/argument types.
package alu_pkg;

    // Width of one ALU slice.
    localparam int SLICE_W = 4;

    // Width of the full ALU datapath assembled from slices by the wrapper.
    localparam int ALU_W   = 8;

    // Width of the wrapper command word.
    localparam int CMD_W   = 5;

    // Operands seen by one slice; d2 arrives already inverted when the
    // wrapper needs ~B (SUB, COMP, XNOR).
    typedef struct packed {
        logic [SLICE_W-1:0] d1;
        logic [SLICE_W-1:0] d2;
    } Alu4bitArgs;

    // Slice result-mux select.
    typedef enum logic [1:0] {
        SUM      = 2'b00,
        AND_OP   = 2'b01,
        OR_OP    = 2'b10,
        RSHFT_OP = 2'b11
    } AluOp;

    // Raw command word presented to the wrapper.
    typedef logic [CMD_W-1:0] AluCmd;

    // Control fields that the wrapper drives into every slice.
    typedef struct packed {
        logic carry_in;
        logic carry_disable;
        AluOp op;
    } AluCtrlInternal;

    // Full wrapper control: operand-B inversion plus the slice controls.
    typedef struct packed {
        logic           invert_d2;
        AluCtrlInternal internal;
    } AluCtrl;

    // Wrapper-level operands.
    typedef struct packed {
        logic [ALU_W-1:0] d1;
        logic [ALU_W-1:0] d2;
    } AluArgs;

    // Wrapper-level result.
    typedef struct packed {
        logic [ALU_W-1:0] res;
        logic             carry_out;
    } AluRet;

endpackage

// File: rtl/alu_4bit_carry_chain.sv
// Carry-lookahead network for one 4-bit slice. Every carry is expressed
// directly from generate/propagate and the slice carry-in, so no carry
// ripples through the previous one. carry_disable forces every carry to 0,
// which also blocks an unknown carry_in from reaching the outputs.
module alu_4bit_carry_chain
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] g,
    input  logic [SLICE_W-1:0] p,
    input  logic               carry_in,
    input  logic               carry_disable,
    output logic [SLICE_W:0]   c
);

    logic               c0;
    logic [SLICE_W-1:0] c_hi;

    assign c0 = carry_in & ~carry_disable;

    genvar gi;
    generate
        for (gi = 0; gi < SLICE_W; gi++) begin : g_lookahead
            logic path;
            logic run;

            // Carry out of bit gi: any lower bit generates and every bit
            // between it and gi propagates, or carry-in propagates through
            // all bits 0..gi.
            always_comb begin
                path = 1'b0;
                run  = 1'b0;
                for (int j = 0; j <= gi; j++) begin
                    run = g[j];
                    for (int k = j + 1; k <= gi; k++) begin
                        run = run & p[k];
                    end
                    path = path | run;
                end
                run = c0;
                for (int k = 0; k <= gi; k++) begin
                    run = run & p[k];
                end
                path = path | run;
            end

            assign c_hi[gi] = path & ~carry_disable;
        end
    endgenerate

    assign c = {c_hi, c0};

endmodule

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU slice: lookahead add with carry-in, carry-suppressed
// XOR, AND, OR and 1-bit right shift. All outputs register one cycle after
// the operands are sampled; a new operation is accepted every cycle.
module alu_4bit
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  Alu4bitArgs         args,
    input  logic               carry_in,
    input  logic               carry_disable,
    input  logic [1:0]         cmd,
    output logic [SLICE_W-1:0] internal_propagate,
    output logic [SLICE_W-1:0] res,
    output logic               carry_out
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    logic [SLICE_W-1:0] res_next;
    logic               carry_out_next;

    logic [SLICE_W-1:0] res_reg;
    logic               carry_out_reg;
    logic [SLICE_W-1:0] propagate_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SLICE_W; gi++) begin : g_bit
            assign g[gi] = args.d1[gi] & args.d2[gi];
            assign p[gi] = args.d1[gi] ^ args.d2[gi];
        end
    endgenerate

    alu_4bit_carry_chain u_carry_chain (
        .g             (g),
        .p             (p),
        .carry_in      (carry_in),
        .carry_disable (carry_disable),
        .c             (c)
    );

    // Result mux. Only RSHFT looks at carry_in directly, so an unknown
    // carry_in under carry_disable stays out of the other operations.
    always_comb begin
        res_next       = '0;
        carry_out_next = 1'b0;
        case (cmd)
            SUM: begin
                res_next       = p ^ c[SLICE_W-1:0];
                carry_out_next = c[SLICE_W];
            end
            AND_OP: begin
                res_next       = args.d1 & args.d2;
                carry_out_next = 1'b0;
            end
            OR_OP: begin
                res_next       = args.d1 | args.d2;
                carry_out_next = 1'b0;
            end
            RSHFT_OP: begin
                res_next       = {carry_in, args.d2[SLICE_W-1:1]};
                carry_out_next = args.d2[0];
            end
            default: begin
                res_next       = '0;
                carry_out_next = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears everything and wins over new operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg       <= '0;
            carry_out_reg <= 1'b0;
            propagate_reg <= '0;
        end else begin
            res_reg       <= res_next;
            carry_out_reg <= carry_out_next;
            propagate_reg <= p;
        end
    end

    assign res                = res_reg;
    assign carry_out          = carry_out_reg;
    assign internal_propagate = propagate_reg;

endmodule

// File: tb/tb_alu_4bit.sv
// Directed and exhaustive check of the registered 4-bit ALU slice.
module tb_alu_4bit;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    Alu4bitArgs args;
    logic       carry_in = 1'b0;
    logic       carry_disable = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [3:0] internal_propagate;
    logic [3:0] res;
    logic       carry_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_4bit dut (
        .clk                (clk),
        .rst                (rst),
        .args               (args),
        .carry_in           (carry_in),
        .carry_disable      (carry_disable),
        .cmd                (cmd),
        .internal_propagate (internal_propagate),
        .res                (res),
        .carry_out          (carry_out)
    );

    // Reference: arithmetic on integers, not a gate-level copy.
    function automatic logic [8:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic ci, input logic cd,
                                             input logic [1:0] op);
        logic [4:0] total;
        logic [3:0] r;
        logic       co;
        r  = 4'h0;
        co = 1'b0;
        case (op)
            2'b00: begin
                if (cd) begin
                    r  = a ^ b;
                    co = 1'b0;
                end else begin
                    total = {1'b0, a} + {1'b0, b} + {4'b0, ci};
                    r  = total[3:0];
                    co = total[4];
                end
            end
            2'b01: r = a & b;
            2'b10: r = a | b;
            default: begin
                r  = {ci, b[3:1]};
                co = b[0];
            end
        endcase
        return {a ^ b, co, r};
    endfunction

    task automatic check_out(input string tag, input logic [3:0] exp_res,
                             input logic exp_co, input logic [3:0] exp_p);
        checks++;
        assert (res === exp_res) else begin
            failures++;
            $error("FAIL %s res observed=%h expected=%h", tag, res, exp_res);
        end
        checks++;
        assert (carry_out === exp_co) else begin
            failures++;
            $error("FAIL %s carry_out observed=%b expected=%b", tag, carry_out, exp_co);
        end
        checks++;
        assert (internal_propagate === exp_p) else begin
            failures++;
            $error("FAIL %s prop observed=%h expected=%h", tag, internal_propagate, exp_p);
        end
        $display("%s: d1=%h d2=%h ci=%b cd=%b cmd=%0d -> res=%h co=%b p=%h",
                 tag, args.d1, args.d2, carry_in, carry_disable, cmd, res, carry_out,
                 internal_propagate);
    endtask

    // Drive on the falling edge, let one rising edge capture, sample 1 time unit later.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        input logic cd, input logic [1:0] op);
        @(negedge clk);
        args.d1       = a;
        args.d2       = b;
        carry_in      = ci;
        carry_disable = cd;
        cmd           = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] exp_v;
        logic [3:0] orig_b;

        args = '0;

        // Reset state
        @(posedge clk);
        #1;
        check_out("reset", 4'h0, 1'b0, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // ADD 9 + 8
        step(4'h9, 4'h8, 1'b0, 1'b0, 2'b00);
        check_out("add_9_8", 4'h1, 1'b1, 4'h1);

        // SUB via inverted B
        step(4'h3, 4'hA, 1'b1, 1'b0, 2'b00);
        check_out("sub_3_5", 4'hE, 1'b0, 4'h9);
        step(4'h7, 4'hA, 1'b1, 1'b0, 2'b00);
        check_out("sub_7_5", 4'h2, 1'b1, 4'hD);

        // Carry-disabled XOR, then AND, OR
        step(4'hC, 4'hA, 1'b1, 1'b1, 2'b00);
        check_out("xor_cd", 4'h6, 1'b0, 4'h6);
        step(4'hC, 4'hA, 1'b1, 1'b1, 2'b01);
        check_out("and", 4'h8, 1'b0, 4'h6);
        step(4'hC, 4'hA, 1'b1, 1'b1, 2'b10);
        check_out("or", 4'hE, 1'b0, 4'h6);

        // X carry_in must be masked by carry_disable
        step(4'h5, 4'h3, 1'bx, 1'b1, 2'b00);
        check_out("xci_sum", 4'h6, 1'b0, 4'h6);

        // RSHFT
        step(4'hF, 4'h5, 1'b1, 1'b0, 2'b11);
        check_out("rshft_ci1", 4'hA, 1'b1, 4'hA);
        step(4'hF, 4'h5, 1'b0, 1'b0, 2'b11);
        check_out("rshft_ci0", 4'h2, 1'b1, 4'hA);
        step(4'h0, 4'h6, 1'b1, 1'b1, 2'b11);
        check_out("rshft_cd", 4'hB, 1'b0, 4'h6);

        // Reset mid-stream while holding F + F
        step(4'hF, 4'hF, 1'b0, 1'b0, 2'b00);
        check_out("add_ff", 4'hE, 1'b1, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_out("mid_reset", 4'h0, 1'b0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_out("post_reset", 4'hE, 1'b1, 4'h0);

        // Exhaustive sweep against the reference model
        for (int op = 0; op < 4; op++) begin
            for (int cd = 0; cd < 2; cd++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    for (int a = 0; a < 16; a++) begin
                        for (int b = 0; b < 16; b++) begin
                            step(4'(a), 4'(b), 1'(ci), 1'(cd), 2'(op));
                            exp_v = ref_model(4'(a), 4'(b), 1'(ci), 1'(cd), 2'(op));
                            checks++;
                            assert (res === exp_v[3:0]) else begin
                                failures++;
                                $error("FAIL sweep_res d1=%0d d2=%0d ci=%0d cd=%0d cmd=%0d observed=%h expected=%h",
                                       a, b, ci, cd, op, res, exp_v[3:0]);
                            end
                            checks++;
                            assert (carry_out === exp_v[4]) else begin
                                failures++;
                                $error("FAIL sweep_co d1=%0d d2=%0d ci=%0d cd=%0d cmd=%0d observed=%b expected=%b",
                                       a, b, ci, cd, op, carry_out, exp_v[4]);
                            end
                            checks++;
                            assert (internal_propagate === exp_v[8:5]) else begin
                                failures++;
                                $error("FAIL sweep_p d1=%0d d2=%0d ci=%0d cd=%0d cmd=%0d observed=%h expected=%h",
                                       a, b, ci, cd, op, internal_propagate, exp_v[8:5]);
                            end
                            // COMP: d2 is ~B, carry_in=0 -> carry_out means d1 > B
                            orig_b = ~(4'(b));
                            if (op == 0 && cd == 0 && ci == 0 && a != int'(orig_b)) begin
                                checks++;
                                assert (carry_out === (a > int'(orig_b))) else begin
                                    failures++;
                                    $error("FAIL comp d1=%0d b=%0d observed=%b expected=%b",
                                           a, orig_b, carry_out, (a > int'(orig_b)));
                                end
                            end
                        end
                    end
                end
            end
        end
        $display("sweep done: %0d vectors", 4 * 2 * 2 * 16 * 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
